// File: rtl/led_flash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_flash_ctrl
// Purpose  : Shares LED1/LED2 between a switch mirror and round-robin RX/TX
//            flash requests. Optional switch debounce: LED_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module led_flash_ctrl #(
  parameter int CLK_HZ      = 50000000,
  parameter int FLASH_MS    = 50,
  parameter int GAP_MS      = 20,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic CLK_50MHZ,
  input  logic RST_N,
  input  logic SWITCH1,
  input  logic REQ_RX,
  input  logic REQ_TX,
  output logic ACK_RX,
  output logic ACK_TX,
  output logic BUSY,
  output logic LED1,
  output logic LED2
);

  localparam int P         = CLK_HZ / 1000;
  localparam int FLASH_CYC = FLASH_MS * P;
  localparam int GAP_CYC   = GAP_MS * P;
  localparam int MAX_CYC   = (FLASH_CYC > GAP_CYC) ? FLASH_CYC : GAP_CYC;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  if ((CLK_HZ < 1000) || ((CLK_HZ % 1000) != 0) || (FLASH_MS < 1) ||
      (GAP_MS < 1) || (DEBOUNCE_MS < 1)) begin : g_bad_params
    $error("led_flash_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLASH_RX = 2'd1,
    ST_FLASH_TX = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Switch synchronizer
  // --------------------------------------------------------------------------
  logic [1:0] sync_q, sync_d;
  logic       sw_s;
  logic       sw_db;

  always_comb begin
    sync_d = {sync_q[0], SWITCH1};
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sw_s = sync_q[1];

`ifdef LED_DEBOUNCE_EN
  localparam int DB_CYC = DEBOUNCE_MS * P;
  localparam int DB_W   = $clog2(DB_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            sw_db_q, sw_db_d;

  // Counter runs only while sw_s disagrees; any agreement restarts the window.
  always_comb begin
    db_cnt_d = '0;
    sw_db_d  = sw_db_q;
    if (sw_s != sw_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        sw_db_d = sw_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      db_cnt_q <= '0;
      sw_db_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      sw_db_q  <= sw_db_d;
    end
  end

  assign sw_db = sw_db_q;
`else
  assign sw_db = sw_s;
`endif

  // --------------------------------------------------------------------------
  // Arbiter / flash sequencer
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_tx_q, last_tx_d;
  logic             ack_rx_q, ack_rx_d;
  logic             ack_tx_q, ack_tx_d;
  logic             busy_q, busy_d;
  logic             led1_q, led1_d;
  logic             led2_q, led2_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    last_tx_d = last_tx_q;
    ack_rx_d  = 1'b0;
    ack_tx_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // RX wins a tie only when TX was the previous grant.
        if (REQ_RX && (!REQ_TX || last_tx_q)) begin
          state_d   = ST_FLASH_RX;
          ack_rx_d  = 1'b1;
          last_tx_d = 1'b0;
        end else if (REQ_TX) begin
          state_d   = ST_FLASH_TX;
          ack_tx_d  = 1'b1;
          last_tx_d = 1'b1;
        end
      end
      ST_FLASH_RX, ST_FLASH_TX: begin
        if (cnt_q == FLASH_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    case (state_d)
      ST_IDLE: begin
        led1_d = sw_db;
        led2_d = ~sw_db;
      end
      ST_FLASH_RX: begin
        led1_d = 1'b1;
        led2_d = 1'b0;
      end
      ST_FLASH_TX: begin
        led1_d = 1'b0;
        led2_d = 1'b1;
      end
      default: begin
        led1_d = 1'b0;
        led2_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_tx_q <= 1'b1;
      ack_rx_q  <= 1'b0;
      ack_tx_q  <= 1'b0;
      busy_q    <= 1'b0;
      led1_q    <= 1'b0;
      led2_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_tx_q <= last_tx_d;
      ack_rx_q  <= ack_rx_d;
      ack_tx_q  <= ack_tx_d;
      busy_q    <= busy_d;
      led1_q    <= led1_d;
      led2_q    <= led2_d;
    end
  end

  assign ACK_RX = ack_rx_q;
  assign ACK_TX = ack_tx_q;
  assign BUSY   = busy_q;
  assign LED1   = led1_q;
  assign LED2   = led2_q;

endmodule
`default_nettype wire

// File: tb/tb_led_flash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_flash_ctrl
// Purpose  : Scoreboard bench for led_flash_ctrl; expected output vectors
//            {ACK_RX,ACK_TX,BUSY,LED1,LED2} are queued per cycle and checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_flash_ctrl;

  localparam int CLK_HZ      = 10000;
  localparam int FLASH_MS    = 3;
  localparam int GAP_MS      = 2;
  localparam int DEBOUNCE_MS = 2;
  localparam int FLASH_CYC   = 30;
  localparam int GAP_CYC     = 20;
  localparam int SVC         = FLASH_CYC + GAP_CYC + 1;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic sw     = 1'b0;
  logic req_rx = 1'b0;
  logic req_tx = 1'b0;
  logic ack_rx, ack_tx, busy, led1, led2;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic idle_led1 = 1'b0;

  typedef struct {
    int         cyc;
    logic [4:0] exp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  led_flash_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .FLASH_MS    (FLASH_MS),
    .GAP_MS      (GAP_MS),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_dut (
    .CLK_50MHZ (clk),
    .RST_N     (rst_n),
    .SWITCH1   (sw),
    .REQ_RX    (req_rx),
    .REQ_TX    (req_tx),
    .ACK_RX    (ack_rx),
    .ACK_TX    (ack_tx),
    .BUSY      (busy),
    .LED1      (led1),
    .LED2      (led2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check_val(e.tag, {27'd0, ack_rx, ack_tx, busy, led1, led2}, {27'd0, e.exp});
    end
  end

  function automatic void expect_at(input int c, input logic [4:0] v, input string tag);
    sb_q.push_back('{c, v, tag});
  endfunction

  function automatic logic [4:0] idle_vec();
    return {3'b000, idle_led1, ~idle_led1};
  endfunction

  // One service window starting at the grant edge k: ack, flash, gap, idle.
  function automatic void push_service(input int k, input bit is_tx, input int len,
                                       input string tag);
    logic [4:0] v;
    for (int i = 0; i < len; i++) begin
      if (i == 0)                       v = is_tx ? 5'b01101 : 5'b10110;
      else if (i < FLASH_CYC)           v = is_tx ? 5'b00101 : 5'b00110;
      else if (i < FLASH_CYC + GAP_CYC) v = 5'b00100;
      else                              v = idle_vec();
      expect_at(k + i, v, tag);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    int k;

    // Reset state
    step(3);
    expect_at(cyc,     5'b00001, "reset");
    expect_at(cyc + 1, 5'b00001, "reset_rel");
    expect_at(cyc + 2, 5'b00001, "reset_rel");
    rst_n = 1'b1;
    step(3);

    // Switch mirror latency
    e0 = cyc;
`ifdef LED_DEBOUNCE_EN
    for (int c = e0 + 1; c <= e0 + 42; c++) expect_at(c, 5'b00001, "sw_glitch");
    for (int c = e0 + 43; c <= e0 + 45; c++) expect_at(c, 5'b00010, "sw_db_edge");
    for (int g = 0; g < 2; g++) begin
      sw = 1'b1; step(5);
      sw = 1'b0; step(5);
    end
    sw = 1'b1;
    step(26);
    idle_led1 = 1'b1;
`else
    expect_at(e0 + 1, 5'b00001, "sw_lat");
    expect_at(e0 + 2, 5'b00001, "sw_lat");
    for (int c = e0 + 3; c <= e0 + 5; c++) expect_at(c, 5'b00010, "sw_pulse");
    for (int c = e0 + 6; c <= e0 + 8; c++) expect_at(c, 5'b00001, "sw_pulse_end");
    sw = 1'b1; step(3);
    sw = 1'b0; step(6);
    idle_led1 = 1'b0;
`endif

    // Both requests held: RX, TX, RX, TX with 51-cycle spacing
    k = cyc + 1;
    for (int g = 0; g < 4; g++) push_service(k + g * SVC, g[0], SVC, "rr_order");
    expect_at(k + 4 * SVC, idle_vec(), "rr_idle");
    req_rx = 1'b1;
    req_tx = 1'b1;
    step(1 + 3 * SVC);
    req_rx = 1'b0;
    req_tx = 1'b0;
    step(SVC + 2);

    // Single RX request with handshake drop after ACK
    k = cyc + 1;
    push_service(k, 1'b0, SVC, "rx_single");
    expect_at(k + SVC, idle_vec(), "rx_idle");
    req_rx = 1'b1;
    step(1);
    req_rx = 1'b0;
    step(SVC + 2);

    // Reset at cycle 10 of FLASH_TX with REQ_TX still high
    k = cyc + 1;
    push_service(k, 1'b1, 10, "tx_pre_rst");
    expect_at(k + 10, 5'b00001, "tx_rst_idle");
    push_service(k + 11, 1'b1, SVC, "tx_regrant");
    expect_at(k + 11 + SVC, idle_vec(), "tx_idle");
    req_tx = 1'b1;
    step(10);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    req_tx = 1'b0;
    step(SVC + 2);

    // Reset during FLASH_RX: pointer back at TX, so RX wins the next tie
    k = cyc + 1;
    push_service(k, 1'b0, 5, "rx_pre_rst");
    expect_at(k + 5, 5'b00001, "rx_rst_idle");
    push_service(k + 6, 1'b0, SVC, "tie_after_rst");
    expect_at(k + 6 + SVC, idle_vec(), "tie_idle");
    req_rx = 1'b1;
    step(1);
    req_tx = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    req_rx = 1'b0;
    req_tx = 1'b0;
    step(SVC + 2);

    for (int i = 0; i < 200 && sb_q.size() > 0; i++) step(1);
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/led_flash_ctrl.md
# led_flash_ctrl

Board-level LED controller that shares the two user LEDs between the slide-switch status mirror and two event requesters, the packet receive and transmit paths. When idle, LED1 follows the switch and LED2 shows its inverse. A request from RX or TX is granted round-robin with a one-cycle acknowledge and shows a timed flash pattern, followed by a dark gap. The block sits at the top level between the board pins and the DNS datapath status strobes.

## Interface
- CLK_HZ, 50000000, clock frequency; must be a multiple of 1000 and at least 1000; P = CLK_HZ/1000 cycles per ms
- FLASH_MS, 50, flash duration in ms, ≥1
- GAP_MS, 20, dark gap after each flash in ms, ≥1
- DEBOUNCE_MS, 10, switch stability window in ms, ≥1; used only with LED_DEBOUNCE_EN
- CLK_50MHZ  in  1  system clock, all logic on rising edge
- RST_N  in  1  synchronous, active-low reset
- SWITCH1  in  1  asynchronous board switch
- REQ_RX  in  1  flash request from RX path; level, held until ACK_RX
- REQ_TX  in  1  flash request from TX path; level, held until ACK_TX
- ACK_RX  out  1  one-cycle grant pulse to RX
- ACK_TX  out  1  one-cycle grant pulse to TX
- BUSY  out  1  high in FLASH_RX, FLASH_TX, GAP
- LED1  out  1  registered LED drive
- LED2  out  1  registered LED drive

## Operation
- Switch path: 2-FF synchronizer into sw_s, then debounce (see Configuration) into sw_db.
- FSM states and LED drive:
  - IDLE: LED1=sw_db, LED2=!sw_db.
  - FLASH_RX: LED1=1, LED2=0.
  - FLASH_TX: LED1=0, LED2=1.
  - GAP: LED1=0, LED2=0.
- Transitions:
  - IDLE→FLASH_RX or FLASH_TX when a request is sampled high; the matching ACK pulses during the first cycle of the FLASH state.
  - FLASH_x→GAP after FLASH_MS*P cycles.
  - GAP→IDLE after GAP_MS*P cycles.
- Arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the requester not granted last. The last-grant pointer resets to TX, so RX wins the first tie.
  - Requests are not sampled outside IDLE.
- Handshake: a requester deasserts REQ by the cycle after its ACK. A REQ still high when the FSM is next in IDLE counts as a new request.
- Duration counter: cleared on every state entry; it counts cycles, width $clog2(max(FLASH_MS,GAP_MS)*P+1).
- Switch changes during FLASH or GAP are still tracked by sw_db; the mirror resumes with the current sw_db on return to IDLE.
- Reset mid-operation:
  - Next state is IDLE; counters, synchronizer, sw_db and pointer are cleared, and ACKs go low.
  - A grant in progress is dropped without an ACK.
  - Requests held through reset are arbitrated afresh after release.

## Timing
- Reset values: LED1=0, LED2=1 (sw_db=0), ACK_RX=0, ACK_TX=0, BUSY=0, state IDLE.
- Grant latency:
  - A REQ sampled high at edge k in IDLE sets state, ACK, BUSY and LEDs at edge k. The ACK is high for exactly cycle k..k+1.
  - The FSM spends a minimum of 1 cycle in IDLE between a GAP and the next grant.
- Flash pattern is held for exactly FLASH_MS*P cycles and the gap for exactly GAP_MS*P cycles. Back-to-back service period is (FLASH_MS+GAP_MS)*P+1 cycles.
- Switch mirror latency: the synchronizer adds 2 cycles, the debounce adds the delay given in Configuration, and the LED register adds 1 cycle.

## Configuration
- LED_DEBOUNCE_EN defined:
  - sw_db takes the value of sw_s on the edge where sw_s has differed from sw_db for DEBOUNCE_MS*P consecutive cycles.
  - Any return of sw_s to equal sw_db clears the stability counter.
  - SWITCH1 edge → LED1 change latency is 2+DEBOUNCE_MS*P+1 cycles.
- LED_DEBOUNCE_EN undefined: sw_db = sw_s; no stability counter is built; latency is 3 cycles.

## Test plan
Bench uses CLK_HZ=10000 (P=10), FLASH_MS=3, GAP_MS=2, DEBOUNCE_MS=2.
- Reset with SWITCH1=0, requests low -> LED1=0, LED2=1, ACK_RX=ACK_TX=0, BUSY=0 in the first cycle after reset.
- With LED_DEBOUNCE_EN: SWITCH1 toggles with 5-cycle glitches, then holds 1 -> no LED change during the glitches; LED1=1 and LED2=0 exactly 23 cycles after the final edge. Without the macro: a 3-cycle pulse appears on LED1 3 cycles later.
- REQ_RX high at edge 0, dropped after ACK -> ACK_RX high cycle 0..1 only; LED1=1/LED2=0 for 30 cycles; both LEDs 0 for 20 cycles; mirror resumes; BUSY high for 50 cycles.
- REQ_RX and REQ_TX held high continuously -> grant order RX, TX, RX, TX; consecutive ACKs 51 cycles apart; never both ACKs high in the same cycle.
- RST_N low for 1 cycle at cycle 10 of FLASH_TX with REQ_TX still high -> IDLE outputs with BUSY=0 on the next cycle; the next grant goes to TX (the sole requester) 1 cycle after release; tie-break pointer is back at TX.
